pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 139 +++++++++++++
 tb/tb_pipe_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/exception controller: per-stage stall vector, single-cycle flush
// with redirect target, post-flush recovery guard, and stall/flush statistics.
module pipe_ctrl #(
  parameter logic [31:0] HANDLER_ADDR   = 32'h00000020,
  parameter int unsigned RECOVER_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cycles_o,
  output logic [15:0] flush_count_o
);

  localparam logic [31:0] ERET_CODE = 32'h0000000E;
  localparam logic [3:0]  REC_LOAD  = 4'(RECOVER_CYCLES);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_RECOVER = 2'd2
  } state_e;

  state_e      state_q;
  logic        flush_q;
  logic [31:0] new_pc_q;
  logic [3:0]  rec_cnt_q;
  logic [15:0] flush_count_q;
  logic [31:0] stall_cycles_q;
  logic [31:0] stall_cycles_d;
  logic [5:0]  stall_s;

  // The deepest requesting stage wins; it holds itself and everything upstream.
  function automatic logic [5:0] stall_vec(input logic mem, input logic ex,
                                           input logic id, input logic ifs);
    logic [5:0] v;
    if (mem) begin
      v = 6'b011111;
    end else if (ex) begin
      v = 6'b001111;
    end else if (id) begin
      v = 6'b000111;
    end else if (ifs) begin
      v = 6'b000011;
    end else begin
      v = 6'b000000;
    end
    return v;
  endfunction

  // Stall vector selection by controller state.
  always_comb begin
    stall_s = 6'b000000;
    case (state_q)
      ST_RUN:     stall_s = stall_vec(stallreq_from_mem, stallreq_from_ex,
                                      stallreq_from_id, stallreq_from_if);
      ST_FLUSH:   stall_s = 6'b000000;
      ST_RECOVER: stall_s = stall_vec(1'b0, 1'b0, stallreq_from_id, stallreq_from_if);
      default:    stall_s = 6'b000000;
    endcase
  end

  // Saturating stall-cycle counter next value.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_s[0] && (stall_cycles_q != 32'hFFFFFFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  // Controller FSM with registered flush, redirect target and flush statistics.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_RUN;
      flush_q       <= 1'b0;
      new_pc_q      <= 32'h00000000;
      rec_cnt_q     <= 4'd0;
      flush_count_q <= 16'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (excepttype_i != 32'h00000000) begin
            state_q       <= ST_FLUSH;
            flush_q       <= 1'b1;
            new_pc_q      <= (excepttype_i == ERET_CODE) ? cp0_epc_i : HANDLER_ADDR;
            flush_count_q <= flush_count_q + 16'd1;
          end else begin
            flush_q <= 1'b0;
          end
        end
        ST_FLUSH: begin
          state_q   <= ST_RECOVER;
          flush_q   <= 1'b0;
          rec_cnt_q <= REC_LOAD;
        end
        ST_RECOVER: begin
          flush_q <= 1'b0;
          // A load below 1 would never terminate by decrement, so <= catches it too.
          if (rec_cnt_q <= 4'd1) begin
            state_q   <= ST_RUN;
            rec_cnt_q <= 4'd0;
          end else begin
            rec_cnt_q <= rec_cnt_q - 4'd1;
          end
        end
        default: begin
          state_q   <= ST_RUN;
          flush_q   <= 1'b0;
          rec_cnt_q <= 4'd0;
        end
      endcase
    end
  end

  // Stall-cycle statistics register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= 32'h00000000;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall          = stall_s;
  assign flush          = flush_q;
  assign new_pc         = new_pc_q;
  assign stall_cycles_o = stall_cycles_q;
  assign flush_count_o  = flush_count_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized and directed bench for pipe_ctrl against a cycle-timeline reference model.
module tb_pipe_ctrl;

  localparam int          R       = 2;
  localparam logic [31:0] HANDLER = 32'h00000020;

  logic        clk;
  logic        rst;
  logic        s_if, s_id, s_ex, s_mem;
  logic [31:0] exc, epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] stall_cycles_o;
  logic [15:0] flush_count_o;

  pipe_ctrl #(.HANDLER_ADDR(HANDLER), .RECOVER_CYCLES(R)) dut (
    .clk(clk), .rst(rst),
    .stallreq_from_if(s_if), .stallreq_from_id(s_id),
    .stallreq_from_ex(s_ex), .stallreq_from_mem(s_mem),
    .excepttype_i(exc), .cp0_epc_i(epc),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .stall_cycles_o(stall_cycles_o), .flush_count_o(flush_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: absolute cycle numbers of the pending flush and of the return to run.
  int          cyc       = 0;
  int          flush_cyc = -1;
  int          run_from  = 0;
  logic [31:0] m_new_pc  = 32'h0;
  logic [31:0] m_stalls  = 32'h0;
  logic [15:0] m_flushes = 16'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    else n_pass++;
  endtask

  task automatic run_cycle(input logic i_if, input logic i_id, input logic i_ex,
                           input logic i_mem, input logic [31:0] i_exc, input logic [31:0] i_epc);
    logic       in_flush, in_rec;
    logic [5:0] exp_stall;
    s_if = i_if; s_id = i_id; s_ex = i_ex; s_mem = i_mem; exc = i_exc; epc = i_epc;
    in_flush = (cyc == flush_cyc);
    in_rec   = !in_flush && (cyc < run_from);
    if (in_flush)      exp_stall = 6'h00;
    else if (in_rec)   exp_stall = i_id ? 6'h07 : (i_if ? 6'h03 : 6'h00);
    else if (i_mem)    exp_stall = 6'h1F;
    else if (i_ex)     exp_stall = 6'h0F;
    else if (i_id)     exp_stall = 6'h07;
    else if (i_if)     exp_stall = 6'h03;
    else               exp_stall = 6'h00;
    @(negedge clk);
    check("stall",        {26'd0, stall},         {26'd0, exp_stall});
    check("flush",        {31'd0, flush},         {31'd0, in_flush});
    check("new_pc",       new_pc,                 m_new_pc);
    check("stall_cycles", stall_cycles_o,         m_stalls);
    check("flush_count",  {16'd0, flush_count_o}, {16'd0, m_flushes});
    @(posedge clk);
    if (exp_stall[0] && m_stalls != 32'hFFFFFFFF) m_stalls = m_stalls + 32'd1;
    if (!in_flush && !in_rec && i_exc != 32'h0) begin
      flush_cyc = cyc + 1;
      run_from  = cyc + 2 + R;
      m_new_pc  = (i_exc == 32'h0000000E) ? i_epc : HANDLER;
      m_flushes = m_flushes + 16'd1;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Entered just after a rising edge; reset must act without waiting for a clock.
  task automatic do_reset();
    rst = 1'b0;
    s_ex = 1'b1; s_mem = 1'b0;
    #1;
    check("rst_flush",        {31'd0, flush},         32'h0);
    check("rst_new_pc",       new_pc,                 32'h0);
    check("rst_stall_cycles", stall_cycles_o,         32'h0);
    check("rst_flush_count",  {16'd0, flush_count_o}, 32'h0);
    check("rst_stall_follow", {26'd0, stall},         32'h0000000F);
    @(posedge clk);
    #1;
    rst = 1'b1;
    s_ex = 1'b0;
    m_new_pc = 32'h0; m_stalls = 32'h0; m_flushes = 16'h0;
    flush_cyc = -1; run_from = cyc;
  endtask

  initial begin
    int r;
    logic [31:0] e;
    rst = 1'b0; s_if = 1'b0; s_id = 1'b0; s_ex = 1'b0; s_mem = 1'b0;
    exc = 32'h0; epc = 32'h0;
    @(posedge clk);
    #1;
    do_reset();

    // ex and if together
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    // plain exception to handler
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h8, 32'h12345678);
    idle(4);
    // eret to EPC, with a simultaneous stall
    run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'hE, 32'h00400100);
    idle(4);
    // requests and exceptions during flush and recovery
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0);
    run_cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h5, 32'h0);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h3, 32'h0);
    run_cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h7, 32'h0);
    idle(3);
    // reset in the middle of a flush
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0);
    check("flush_before_rst", {31'd0, flush}, 32'h1);
    do_reset();
    idle(5);
    // exception held for six cycles
    for (int i = 0; i < 6; i++) run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0);
    idle(4);
    check("held_exc_flushes", {16'd0, flush_count_o}, 32'h2);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        r = $urandom_range(0, 9);
        e = (r == 0) ? 32'hE : ((r == 1) ? ($urandom | 32'h1) : 32'h0);
        run_cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 5) == 0),
                  e, $urandom);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
